hilo_wb: RTL and testbench

HILO_WB -- requirements
Module: hilo_wb

---
 rtl/hilo_wb.sv | 97 +++++++++
 tb/tb_hilo_wb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hilo_wb.sv
// HI/LO write-back with a one-entry speculative buffer: writes wait in the buffer
// until their instruction commits, are forwarded to MFHI/MFLO, and are squashed on flush.
module hilo_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic        wr_hi_en,
  input  logic        wr_lo_en,
  input  logic [31:0] wr_hi,
  input  logic [31:0] wr_lo,
  output logic        wr_ready,
  input  logic        commit,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hi_arch,
  output logic [31:0] lo_arch,
  output logic        pending
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] arch_hi_q, arch_hi_d;
  logic [31:0] arch_lo_q, arch_lo_d;
  logic        buf_hi_en_q, buf_hi_en_d;
  logic        buf_lo_en_q, buf_lo_en_d;
  logic [31:0] buf_hi_q, buf_hi_d;
  logic [31:0] buf_lo_q, buf_lo_d;
  logic        capture;

  // Handshake: a write transfers on an edge where wr_valid && wr_ready && !flush.
  // wr_ready is high when the buffer is empty, or when the held entry retires this
  // cycle without a flush, so a back-to-back write can replace it.
  always_comb begin
    state_d     = state_q;
    arch_hi_d   = arch_hi_q;
    arch_lo_d   = arch_lo_q;
    buf_hi_en_d = buf_hi_en_q;
    buf_lo_en_d = buf_lo_en_q;
    buf_hi_d    = buf_hi_q;
    buf_lo_d    = buf_lo_q;
    wr_ready    = (state_q == EMPTY) || (commit && !flush);
    capture     = wr_valid && wr_ready && !flush;

    case (state_q)
      EMPTY: begin
        if (capture) state_d = HELD;
      end
      HELD: begin
        if (commit) begin
          if (buf_hi_en_q) arch_hi_d = buf_hi_q;
          if (buf_lo_en_q) arch_lo_d = buf_lo_q;
          state_d = capture ? HELD : EMPTY;
        end else if (flush) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (capture) begin
      buf_hi_en_d = wr_hi_en;
      buf_lo_en_d = wr_lo_en;
      buf_hi_d    = wr_hi;
      buf_lo_d    = wr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      arch_hi_q   <= '0;
      arch_lo_q   <= '0;
      buf_hi_en_q <= 1'b0;
      buf_lo_en_q <= 1'b0;
      buf_hi_q    <= '0;
      buf_lo_q    <= '0;
    end else begin
      state_q     <= state_d;
      arch_hi_q   <= arch_hi_d;
      arch_lo_q   <= arch_lo_d;
      buf_hi_en_q <= buf_hi_en_d;
      buf_lo_en_q <= buf_lo_en_d;
      buf_hi_q    <= buf_hi_d;
      buf_lo_q    <= buf_lo_d;
    end
  end

  // pending doubles as the FSM state observation point.
  assign pending = (state_q == HELD);
  assign hi      = (pending && buf_hi_en_q) ? buf_hi_q : arch_hi_q;
  assign lo      = (pending && buf_lo_en_q) ? buf_lo_q : arch_lo_q;
  assign hi_arch = arch_hi_q;
  assign lo_arch = arch_lo_q;

endmodule

// File: tb/tb_hilo_wb.sv
// Randomized plus directed bench for hilo_wb against a queue-based reference model
// of uncommitted writes and the architectural HI/LO pair.
module tb_hilo_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_hi_en, wr_lo_en;
  logic [31:0] wr_hi, wr_lo;
  logic        wr_ready, commit, flush;
  logic [31:0] hi, lo, hi_arch, lo_arch;
  logic        pending;

  always #5 clk = ~clk;

  hilo_wb dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_hi_en (wr_hi_en),
    .wr_lo_en (wr_lo_en),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wr_ready (wr_ready),
    .commit   (commit),
    .flush    (flush),
    .hi       (hi),
    .lo       (lo),
    .hi_arch  (hi_arch),
    .lo_arch  (lo_arch),
    .pending  (pending)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Scoreboard: uncommitted writes, packed {hi_en, lo_en, hi[31:0], lo[31:0]}.
  logic [65:0] exp_q[$];
  logic [31:0] m_arch_hi, m_arch_lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input bit rst, input bit wv, input bit he, input bit le,
                     input logic [31:0] h, input logic [31:0] l, input bit c, input bit f);
    bit          held, rdy;
    logic [31:0] e_hi, e_lo;
    logic [65:0] e;
    reset = rst; wr_valid = wv; wr_hi_en = he; wr_lo_en = le;
    wr_hi = h; wr_lo = l; commit = c; flush = f;
    #1;
    held = (exp_q.size() != 0);
    rdy  = !held || (c && !f);
    e_hi = m_arch_hi;
    e_lo = m_arch_lo;
    if (held) begin
      e = exp_q[0];
      if (e[65]) e_hi = e[63:32];
      if (e[64]) e_lo = e[31:0];
    end
    check("hi",       hi,               e_hi);
    check("lo",       lo,               e_lo);
    check("hi_arch",  hi_arch,          m_arch_hi);
    check("lo_arch",  lo_arch,          m_arch_lo);
    check("pending",  {31'd0, pending}, {31'd0, held});
    check("wr_ready", {31'd0, wr_ready}, {31'd0, rdy});
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_arch_hi = '0;
      m_arch_lo = '0;
    end else begin
      if (held && c) begin
        e = exp_q.pop_front();
        if (e[65]) m_arch_hi = e[63:32];
        if (e[64]) m_arch_lo = e[31:0];
      end else if (held && f) begin
        exp_q.delete();
      end
      if (wv && rdy && !f) exp_q.push_back({he, le, h, l});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_hi_en = 1'b0; wr_lo_en = 1'b0;
    wr_hi = '0; wr_lo = '0; commit = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    m_arch_hi = '0;
    m_arch_lo = '0;

    // Reset and basic write/commit, including garbage on inputs while reset is high.
    cyc(1, 1, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Lo-only write then flush.
    cyc(0, 1, 0, 1, 0, 32'h0000_1234, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Commit plus same-cycle hi-only write.
    cyc(0, 1, 1, 1, 32'h1111_2222, 32'h3333_4444, 0, 0);
    cyc(0, 1, 1, 0, 32'hAAAA_5555, 32'h0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Backpressure for three cycles, accepted on the commit cycle.
    cyc(0, 1, 0, 1, 32'h0, 32'h5555_AAAA, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 32'h0BAD_CAFE, 32'h0000_0007, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 32'h0123_4567, 32'h89AB_CDEF, 0, 0);
    cyc(0, 1, 1, 1, 32'h0123_4567, 32'h89AB_CDEF, 1, 0);
    // Commit+flush+write together drops the write.
    cyc(0, 1, 1, 1, 32'hFEED_0001, 32'hFEED_0002, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // No-op entry, commit while empty, flush while empty with a write.
    cyc(0, 1, 0, 0, 32'h7777_7777, 32'h8888_8888, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 32'h9999_9999, 32'h9999_9999, 0, 1);
    // Reset mid-HELD.
    cyc(0, 1, 1, 1, 32'h1357_9BDF, 32'h2468_ACE0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1), $urandom_range(0, 1),
          rand_data(), rand_data(),
          $urandom_range(0, 1), $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
